// File: rtl/spmv_iter_ctrl.sv
// Iteration controller for an SpMV solver: runs the kernel num_iters times,
// flipping the x / x_n ping-pong select between iterations and guarding each one with a timeout.
module spmv_iter_ctrl #(
    parameter int ITER_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ITER_WIDTH-1:0] num_iters,
    output logic                  kernel_en,
    input  logic                  kernel_done,
    output logic                  ping,
    output logic                  busy,
    output logic                  finished,
    output logic                  error,
    output logic [ITER_WIDTH-1:0] iter_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_TERM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, RUN, SWAP, DONE, ERR} state_t;

    state_t                state;
    logic [ITER_WIDTH-1:0] iter_target;
    logic [TW-1:0]         tmo_count;
    logic                  timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_count == TIMEOUT_TERM);

    // Priority inside RUN: abort, then kernel_done, then timeout, so a completion
    // landing on the terminal count still counts as a good iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            iter_target <= '0;
            tmo_count   <= '0;
            kernel_en   <= 1'b0;
            ping        <= 1'b0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            error       <= 1'b0;
            iter_count  <= '0;
        end else begin
            finished <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        iter_target <= num_iters;
                        iter_count  <= '0;
                        ping        <= 1'b0;
                        error       <= 1'b0;
                        tmo_count   <= '0;
                        if (num_iters != '0) begin
                            state     <= RUN;
                            kernel_en <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state    <= DONE;
                            finished <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        kernel_en <= 1'b0;
                        busy      <= 1'b0;
                    end else if (kernel_done) begin
                        state      <= SWAP;
                        kernel_en  <= 1'b0;
                        ping       <= ~ping;
                        iter_count <= iter_count + 1'b1;
                    end else if (timeout_hit) begin
                        state     <= ERR;
                        kernel_en <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                    end else begin
                        tmo_count <= tmo_count + 1'b1;
                    end
                end
                SWAP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (iter_count < iter_target) begin
                        state     <= RUN;
                        kernel_en <= 1'b1;
                        tmo_count <= '0;
                    end else begin
                        state    <= DONE;
                        finished <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
